// File: rtl/adc_event_framer.sv
// rtl/adc_event_framer.sv - frames ADC acquisition windows into header/sample/trailer events behind a FWFT FIFO
//
// Purpose: wraps each AcqActive window into {header, samples, trailer} words,
// buffers them in a first-word-fall-through FIFO and drains over valid/ready.
//
// Ports:
//   Clk            system clock
//   reset_n        asynchronous active-low reset
//   AcqActive      acquisition window level
//   InData[15:0]   sample word (bit 12 = out-of-range flag)
//   InData_en      single-cycle strobe qualifying InData
//   OutData[15:0]  framed word at the FIFO head (0 when empty)
//   OutValid       FIFO non-empty
//   OutReady       consumer accepts OutData this cycle
//   Busy           framer is not idle
//   DroppedEvents  events skipped for lack of FIFO space, saturating at 255

module adc_event_framer #(
  parameter int         FIFO_AW     = 6,
  parameter logic [3:0] HEADER_TAG  = 4'hA,
  parameter logic [3:0] TRAILER_TAG = 4'hC
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        AcqActive,
  input  logic [15:0] InData,
  input  logic        InData_en,
  output logic [15:0] OutData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Busy,
  output logic [7:0]  DroppedEvents
);

  localparam int                DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  DEPTH_W = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SKIP, S_HEADER, S_COLLECT, S_TRAILER
  } state_e;

  state_e       state_q;
  logic         act_q;
  logic [11:0]  event_cnt_q;
  logic [9:0]   sample_cnt_q;
  logic         ovf_q;
  logic         otr_q;
  logic [7:0]   dropped_q;
  logic         skid_v_q;
  logic [15:0]  skid_q;
  logic         pend_fall_q;

  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q;
  logic [FIFO_AW-1:0] rptr_q;
  logic [FIFO_AW:0]   level_q;

  logic             rise, fall;
  logic [FIFO_AW:0] free;
  logic             room3, room2;
  logic             rd_en;
  logic             wr_en;
  logic [15:0]      wr_data;
  logic             smp_take;
  logic [15:0]      smp_word;

  assign rise  = AcqActive & ~act_q;
  assign fall  = ~AcqActive & act_q;
  assign free  = DEPTH_W - level_q;
  assign room3 = (free >= (FIFO_AW + 1)'(3));
  assign room2 = (free >= (FIFO_AW + 1)'(2));

  assign OutValid      = (level_q != '0);
  assign OutData       = OutValid ? mem_q[rptr_q] : 16'h0000;
  assign rd_en         = OutValid & OutReady;
  assign Busy          = (state_q != S_IDLE);
  assign DroppedEvents = dropped_q;

  // Write-port arbitration. A sample candidate (skid first, then live) is only
  // written while two or more entries are free, so the trailer always fits.
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = 16'h0000;
    smp_take = 1'b0;
    smp_word = 16'h0000;
    case (state_q)
      S_HEADER: begin
        wr_en   = 1'b1;
        wr_data = {HEADER_TAG, event_cnt_q};
      end
      S_COLLECT: begin
        if (skid_v_q) begin
          smp_take = 1'b1;
          smp_word = skid_q;
        end else if (InData_en) begin
          smp_take = 1'b1;
          smp_word = InData;
        end
      end
      S_TRAILER: begin
        if (skid_v_q) begin
          smp_take = 1'b1;
          smp_word = skid_q;
        end else begin
          wr_en   = 1'b1;
          wr_data = {TRAILER_TAG, ovf_q, otr_q, sample_cnt_q};
        end
      end
      default: ;
    endcase
    if (smp_take && room2) begin
      wr_en   = 1'b1;
      // upper three bits are scrubbed to zero
      wr_data = {smp_word[15:13] & 3'b000, smp_word[12:0]};
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      act_q        <= 1'b0;
      event_cnt_q  <= 12'd0;
      sample_cnt_q <= 10'd0;
      ovf_q        <= 1'b0;
      otr_q        <= 1'b0;
      dropped_q    <= 8'd0;
      skid_v_q     <= 1'b0;
      skid_q       <= 16'h0000;
      pend_fall_q  <= 1'b0;
    end else begin
      act_q <= AcqActive;
      if (smp_take) begin
        if (room2) begin
          if (sample_cnt_q != 10'h3FF) sample_cnt_q <= sample_cnt_q + 10'd1;
          otr_q <= otr_q | smp_word[12];
        end else begin
          ovf_q <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            if (room3) begin
              state_q <= S_HEADER;
            end else begin
              state_q <= S_SKIP;
              if (dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
            end
          end
        end
        S_SKIP: begin
          if (fall) state_q <= S_IDLE;
        end
        S_HEADER: begin
          sample_cnt_q <= 10'd0;
          ovf_q        <= 1'b0;
          otr_q        <= 1'b0;
          skid_v_q     <= InData_en;
          skid_q       <= InData;
          // a window this short still closes once COLLECT is reached
          pend_fall_q  <= fall;
          state_q      <= S_COLLECT;
        end
        S_COLLECT: begin
          // skid is draining this cycle, so a live sample takes its place
          if (skid_v_q) begin
            skid_v_q <= InData_en;
            skid_q   <= InData;
          end
          if (fall || pend_fall_q) begin
            pend_fall_q <= 1'b0;
            state_q     <= S_TRAILER;
          end
        end
        S_TRAILER: begin
          if (skid_v_q) begin
            skid_v_q <= 1'b0;
          end else begin
            event_cnt_q <= event_cnt_q + 12'd1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wptr_q] <= wr_data;
  end

endmodule
